// File: rtl/coin_pkg.sv
// Shared constants and helpers for the coin acceptor front end.
package coin_pkg;

  localparam int DEBOUNCE_DEFAULT = 16;

  // Counter must hold values up to cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-FF synchroniser, persistence-count debouncer and
// a rising-edge strobe on the debounced level.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic hit
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             synced;

  assign synced = sync_q[1];
  assign level  = stable_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // The counter only advances while the synced input disagrees with the
  // debounced level; any agreement restarts it, so short glitches are lost.
  always_comb begin
    sync_d   = {sync_q[0], raw};
    stable_d = stable_q;
    cnt_d    = '0;
    hit      = 1'b0;
    if (synced != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = synced;
        hit      = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: two debounced sensor channels feeding one-deep
// pending flags, a fixed-priority issue stage and an overflow reject pulse.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic coin5_raw,
  input  logic coin10_raw,
  input  logic busy,
  output logic five,
  output logic ten,
  output logic reject
);

  logic level5, level10;
  logic hit5, hit10;

  logic pend5_q, pend5_d;
  logic pend10_q, pend10_d;
  logic five_q, five_d;
  logic ten_q, ten_d;
  logic reject_q, reject_d;

  logic consume5, consume10;
  logic overflow5, overflow10;

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb5 (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (coin5_raw),
    .level   (level5),
    .hit     (hit5)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb10 (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (coin10_raw),
    .level   (level10),
    .hit     (hit10)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend5_q  <= 1'b0;
      pend10_q <= 1'b0;
      five_q   <= 1'b0;
      ten_q    <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      pend5_q  <= pend5_d;
      pend10_q <= pend10_d;
      five_q   <= five_d;
      ten_q    <= ten_d;
      reject_q <= reject_d;
    end
  end

  // The 5 channel wins whenever both are pending; a strobe landing on a
  // flag that is being consumed the same edge simply re-arms it.
  always_comb begin
    consume5   = !busy && pend5_q;
    consume10  = !busy && !pend5_q && pend10_q;
    overflow5  = hit5 && pend5_q && !consume5;
    overflow10 = hit10 && pend10_q && !consume10;

    pend5_d  = hit5 || (pend5_q && !consume5);
    pend10_d = hit10 || (pend10_q && !consume10);
    five_d   = consume5;
    ten_d    = consume10;
    reject_d = overflow5 || overflow10;
  end

  assign five   = five_q;
  assign ten    = ten_q;
  assign reject = reject_q;

  // A strobe is only produced while the debounced level is still low.
  a_hit5_from_low: assert property (@(posedge clk) disable iff (!reset_n)
    hit5 |-> !level5);
  a_hit10_from_low: assert property (@(posedge clk) disable iff (!reset_n)
    hit10 |-> !level10);
  a_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(five && ten));

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed, table-driven bench for coin_acceptor with D=4, plus hand-written
// sequences for asynchronous reset and controller back-pressure.
module tb_coin_acceptor;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic coin5_raw = 1'b0;
  logic coin10_raw = 1'b0;
  logic busy = 1'b0;
  logic five, ten, reject;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic c5;
    logic c10;
    logic busy;
    logic five;
    logic ten;
    logic reject;
  } vec_t;

  vec_t vecs[$];

  coin_acceptor #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .coin5_raw  (coin5_raw),
    .coin10_raw (coin10_raw),
    .busy       (busy),
    .five       (five),
    .ten        (ten),
    .reject     (reject)
  );

  always #5 clk = ~clk;

  task automatic add(input int n, input logic c5, input logic c10, input logic b,
                     input logic f, input logic t, input logic r);
    vec_t v;
    v.c5 = c5; v.c10 = c10; v.busy = b; v.five = f; v.ten = t; v.reject = r;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic f, input logic t, input logic r);
    check_bit({tag, ".five"}, five, f);
    check_bit({tag, ".ten"}, ten, t);
    check_bit({tag, ".reject"}, reject, r);
  endtask

  // Drive inputs just after an edge; they are sampled on the next rising edge.
  task automatic apply_stimulus(input logic c5, input logic c10, input logic b);
    coin5_raw  = c5;
    coin10_raw = c10;
    busy       = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Clean 5 coin: ten raw samples high, five in the cycle after edge 6.
    add(6, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 0);
    add(3, 1, 0, 0, 0, 0, 0);
    add(6, 0, 0, 0, 0, 0, 0);
    // Glitch shorter than D on the 10 line.
    add(3, 0, 1, 0, 0, 0, 0);
    add(8, 0, 0, 0, 0, 0, 0);
    // Simultaneous coins: five after edge 6, ten after edge 7.
    add(6, 1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 1, 0, 0);
    add(1, 1, 1, 0, 0, 1, 0);
    add(2, 1, 1, 0, 0, 0, 0);
    add(6, 0, 0, 0, 0, 0, 0);
    // Busy hold and overflow: second 5 coin strobes at relative edge 17.
    add(6, 1, 0, 1, 0, 0, 0);
    add(6, 0, 0, 1, 0, 0, 0);
    add(5, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 1);
    add(3, 1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    add(7, 0, 0, 0, 0, 0, 0);

    reset_n = 1'b0;
    #12;
    check_output("reset_held", 1'b0, 1'b0, 1'b0);
    #11 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("after_reset", 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].c5, vecs[i].c10, vecs[i].busy);
      check_output($sformatf("vec%0d", i), vecs[i].five, vecs[i].ten, vecs[i].reject);
    end

    // Reset at edge 3 of a coin whose four high samples would otherwise debounce.
    for (int r = 0; r < 4; r++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0);
      check_output($sformatf("rst_mid_pre%0d", r), 1'b0, 1'b0, 1'b0);
    end
    #2 reset_n = 1'b0;
    #1 check_output("rst_mid_low", 1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b1;
    for (int r = 4; r < 13; r++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output($sformatf("rst_mid_post%0d", r), 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset while five is high drops it before the next edge.
    for (int r = 0; r < 7; r++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0);
      check_output($sformatf("rst_out%0d", r), (r == 6), 1'b0, 1'b0);
    end
    #2 reset_n = 1'b0;
    #1 check_output("rst_out_async", 1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b1;
    for (int r = 7; r < 13; r++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output($sformatf("rst_out%0d", r), 1'b0, 1'b0, 1'b0);
    end

    // Controller integration: 5, 5 then 10; done (busy) rises after the
    // second five and holds the pending 10 coin until it falls.
    for (int r = 0; r < 35; r++) begin
      apply_stimulus((r <= 5) || (r >= 12 && r <= 17),
                     (r >= 14 && r <= 19),
                     (r >= 19 && r <= 28));
      check_output($sformatf("ctrl%0d", r), (r == 6) || (r == 18), (r == 29), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end conditioner that sits directly upstream of the vending-machine controller. It turns two raw mechanical coin-sensor lines into clean, single-cycle, mutually exclusive `five`/`ten` pulses. Each line is synchronised and debounced. A coin that arrives while the controller is busy is held, and a coin that cannot be held is flagged for return. Outputs connect straight to the controller's `five` and `ten` inputs; `busy` is driven from the controller's `done`.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a synchronised input must differ from its debounced value before the debounced value changes; legal range 2..255.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width; derived, not overridden.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `coin5_raw`  input  1  raw, asynchronous 5-unit sensor line; high while a coin breaks the beam.
- `coin10_raw`  input  1  raw, asynchronous 10-unit sensor line.
- `busy`  input  1  high while downstream cannot accept a coin (controller `done`).
- `five`  output  1  registered one-cycle pulse: one 5-unit coin accepted.
- `ten`  output  1  registered one-cycle pulse: one 10-unit coin accepted.
- `reject`  output  1  registered one-cycle pulse: a coin was detected but could not be held; the mechanism must return it.

## Operation
- **Synchroniser:** each raw line passes through a 2-FF synchroniser, reset to 0.
- **Debouncer (per channel):** holds `stable` (reset 0) and `cnt` (reset 0).
  - If synced == `stable`: `cnt` <= 0.
  - If synced != `stable` and `cnt` < D-1: `cnt` <= `cnt`+1.
  - If synced != `stable` and `cnt` == D-1: `stable` <= synced and `cnt` <= 0.
  - `hit` is a combinational strobe, true on the edge where `stable` goes 0->1. Falling transitions produce no strobe.
  - Any glitch shorter than D cycles never changes `stable`.
- **Pending flags:** one per channel, `pend5` and `pend10`, reset 0.
  - `hit` sets the channel's flag.
  - If `hit` arrives while the flag is already 1 and is not being consumed on that edge, `reject` <= 1 for one cycle and the flag stays 1.
  - If `hit` and consumption happen on the same edge, the flag stays 1 and there is no reject.
  - If both channels would reject on the same edge, a single `reject` pulse is issued.
- **Issue:** evaluated on each edge.
  - If `busy` is 0 and `pend5` is 1: `five` <= 1 and `pend5` is cleared.
  - Else, if `busy` is 0 and `pend10` is 1: `ten` <= 1 and `pend10` is cleared.
  - Otherwise `five` and `ten` <= 0.
  - 5 has fixed priority. `five` and `ten` are never high in the same cycle, and never high on consecutive cycles for the same flag unless a new `hit` occurred.
- **Busy hold:** while `busy` is 1, pending coins are held indefinitely and issue on the first edge that samples `busy` == 0.
- **Reset:** asserting `reset_n` low at any time clears synchronisers, counters, `stable`, pending flags and all outputs immediately. A coin in progress is lost.

## Timing
- **Reset values:** `five`, `ten` and `reject` are all 0 during and after reset.
- **Latency:** raw held high from sampling edge 0 gives:
  - synced high after edge 1;
  - `stable` and pend set at edge D+1;
  - `five`/`ten` high for the cycle following edge D+2.
  - Total is D+3 edges, with `busy` low and no competing pending coin.
- **Reject timing:** `reject` goes high the cycle after the offending `hit` edge and lasts exactly one cycle.
- **Simultaneous coins:** both coins debounced on the same edge give `five` first, then `ten` on the next edge (with `busy` low).
- **Busy sampling:** `busy` is sampled on the same edge that would register `five`/`ten`. No combinational path exists from `busy` to any output.
- **Re-arming:** a channel cannot strobe again until its raw line has been low for D cycles and high again for D cycles.

## Structure
- **Package `coin_pkg`:** holds `DEBOUNCE_DEFAULT` = 16 and the debounce-width helper.
- **Sub-module `coin_debounce`:** contains the 2-FF synchroniser, counter, `stable` register and `hit` strobe.
  - Parameters: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `reset_n`, `raw`, `level`, `hit`.
  - Instantiated twice.
- **Top level:** pending flags, priority issue and reject logic.

## Test plan
All scenarios use D=4.
- **Clean 5 coin:** `coin5_raw` high from edge 0 for 10 cycles, `busy`=0 -> `five` high exactly in the cycle after edge 6; `ten` and `reject` stay 0.
- **Glitch filter:** `coin10_raw` high for 3 cycles, then low -> no `ten` pulse, `stable` never changes.
- **Simultaneous coins:** both raw lines rise on the same edge -> `five` after edge 6, `ten` after edge 7, never overlapping.
- **Busy hold and overflow:**
  - `busy`=1 while two 5 coins debounce -> one `reject` pulse after the second strobe.
  - Drop `busy` -> exactly one `five` on the next edge.
- **Reset mid-debounce:** pulse `reset_n` low asynchronously at edge 3 of a 5-unit coin -> all outputs drop to 0 immediately; no `five` follows unless the coin is re-debounced.
- **Controller integration:** 5, 5 then 10 into the downstream controller -> `done` observed, `busy` holds the third coin, which issues only after `done` falls.
